apb_cmd_master: RTL and testbench

Fabric-side APB3 initiator: it accepts single read/write commands over a valid/ready handshake and executes each one as a compliant APB3 transfer. It honours PREADY wait states and returns read data plus error and timeout status on a response handshake. It sits between fabric control logic (e.g. a failsafe motor-stop sequencer) and an APB3 slave such as the H-bridge controller, so fabric logic can drive peripherals without going through the MSS.

---
 rtl/apb_cmd_master.sv | 117 +++++++++++
 tb/tb_apb_cmd_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: executes valid/ready commands as APB3 transfers with wait-state timeout
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic                  psel_q, penable_q, rsp_valid_q;
  logic                  limit_hit;
  // the wait that would make this ACCESS cycle the TIMEOUT_CYCLES-th without PREADY
  assign limit_hit   = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) + 1 == TIMEOUT_CYCLES);
  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  // next state, command capture, completion/timeout capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        pwrite_d = cmd_write;
        paddr_d  = cmd_addr;
        pwdata_d = cmd_wdata;
        state_d  = SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: if (PREADY) begin
        err_d   = PSLVERR;
        rdata_d = pwrite_q ? '0 : PRDATA;
        tmo_d   = 1'b0;
        state_d = RESP;
      end else if (limit_hit) begin
        err_d   = 1'b1;
        rdata_d = '0;
        tmo_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  // state and registered outputs; APB strobes decode the upcoming state
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= (state_d == RESP);
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized APB command bench with transaction-level reference model
module tb_apb_cmd_master;
  localparam int TMO = 8;
  localparam int N = 40;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  int          n_checks = 0, n_fail = 0;
  logic        t_wr[N+2];
  logic        t_err[N+2];
  logic [31:0] t_addr[N+2];
  logic [31:0] t_wdata[N+2];
  logic [31:0] t_prdata[N+2];
  int          t_waits[N+2];
  int          t_hold[N+2];

  apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int i);
    int          n, pc, ac, acc_e;
    logic        tmo_e, err_e, done;
    logic [31:0] rd_e;
    tmo_e = (t_waits[i] >= TMO);
    acc_e = tmo_e ? TMO : t_waits[i] + 1;
    err_e = tmo_e || t_err[i];
    rd_e  = (tmo_e || t_wr[i]) ? 32'd0 : t_prdata[i];
    cmd_write = t_wr[i];
    cmd_addr  = t_addr[i];
    cmd_wdata = t_wdata[i];
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    n = 0; pc = 0; ac = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge PCLK);
      n++;
      cmd_valid = 1'($urandom_range(0, 1));
      if (rsp_valid) done = 1'b1;
      else begin
        if (PSEL) begin
          pc++;
          chk("paddr_hold", PADDR, t_addr[i]);
          chk("pwdata_hold", PWDATA, t_wdata[i]);
          chk("pwrite_hold", 32'(PWRITE), 32'(t_wr[i]));
        end
        if (PSEL && PENABLE) begin
          ac++;
          PREADY  = (ac > t_waits[i]);
          PRDATA  = PREADY ? t_prdata[i] : $urandom;
          PSLVERR = PREADY ? t_err[i] : 1'($urandom_range(0, 1));
        end else begin
          PREADY  = 1'($urandom_range(0, 1));
          PRDATA  = $urandom;
          PSLVERR = 1'($urandom_range(0, 1));
        end
      end
    end
    chk("rsp_latency", 32'(n), 32'(2 + acc_e));
    if (!done) return;
    chk("psel_cycles", 32'(pc), 32'(acc_e + 1));
    chk("access_cycles", 32'(ac), 32'(acc_e));
    chk("rsp_rdata", rsp_rdata, rd_e);
    chk("rsp_err", 32'(rsp_err), 32'(err_e));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(tmo_e));
    chk("psel_in_resp", 32'({PSEL, PENABLE}), 32'd0);
    PREADY    = 1'b0;
    cmd_write = t_wr[i+1];
    cmd_addr  = t_addr[i+1];
    cmd_wdata = t_wdata[i+1];
    cmd_valid = 1'b1;
    for (int h = 0; h < t_hold[i]; h++) begin
      @(negedge PCLK);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, rd_e);
      chk("bp_err", 32'(rsp_err), 32'(err_e));
      chk("bp_timeout", 32'(rsp_timeout), 32'(tmo_e));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel", 32'(PSEL), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_psel_gap", 32'(PSEL), 32'd0);
  endtask

  initial begin
    int seen;
    for (int k = 0; k < N + 2; k++) begin
      t_wr[k]     = 1'($urandom_range(0, 1));
      t_err[k]    = 1'($urandom_range(0, 1));
      t_addr[k]   = $urandom;
      t_wdata[k]  = $urandom;
      t_prdata[k] = $urandom;
      t_waits[k]  = $urandom_range(0, 10);
      t_hold[k]   = $urandom_range(0, 3);
    end
    t_wr[0] = 1'b1; t_addr[0] = 32'h4005_0004; t_wdata[0] = 32'h0000_C350;
    t_waits[0] = 0; t_err[0] = 1'b0; t_hold[0] = 0;
    t_wr[1] = 1'b0; t_addr[1] = 32'h4005_0008; t_prdata[1] = 32'hDEAD_BEEF;
    t_waits[1] = 3; t_err[1] = 1'b0; t_hold[1] = 0;
    t_wr[2] = 1'b1; t_waits[2] = 1; t_err[2] = 1'b1; t_hold[2] = 0;
    t_wr[3] = 1'b0; t_waits[3] = 20; t_hold[3] = 0;
    t_wr[4] = 1'b0; t_waits[4] = TMO - 1; t_err[4] = 1'b0; t_hold[4] = 0;
    t_wr[5] = 1'b1; t_waits[5] = 0; t_hold[5] = 5;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err_tmo", 32'({rsp_err, rsp_timeout}), 32'd0);
    PRESET = 1'b0;
    for (int k = 0; k < N; k++) xfer(k);
    cmd_write = 1'b0;
    cmd_addr  = 32'h4005_000C;
    cmd_valid = 1'b1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("mid_rst_in_access", 32'({PSEL, PENABLE}), 32'd3);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("mid_rst_psel", 32'(PSEL), 32'd0);
    chk("mid_rst_penable", 32'(PENABLE), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) seen++;
    end
    chk("mid_rst_no_rsp", 32'(seen), 32'd0);
    xfer(N);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
